awgn_channel: RTL

//  Downstream consumer of the awgn generator's 16-bit noise sample stream. Maps incoming

---
 rtl/awgn_pkg.sv | 33 +++
 rtl/awgn_scale_mult.sv | 58 +++++
 rtl/awgn_channel.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/awgn_pkg.sv
// Package awgn_pkg
//  Shared number formats and helpers for the awgn generator, the awgn_channel
//  consumer and the bit-error checker.
//  - Q4.11 signed sample format (awgn samples, soft symbols)
//  - Q1.15 unsigned sigma multiplier format
//  - BPSK_POS / BPSK_NEG: +1.0 / -1.0 in Q4.11
//  - sat_w(): clamp a signed value into a w-bit two's-complement range
package awgn_pkg;

  localparam int AWGN_W        = 16;    // sample / scale word width
  localparam int Q_FRAC        = 11;    // fractional bits of Q4.11
  localparam int SCALE_FR_DEF  = 15;    // fractional bits of Q1.15
  localparam int AMP_DEF       = 2048;  // 1.0 in Q4.11
  localparam int FRAME_LEN_DEF = 1024;

  localparam logic signed [AWGN_W-1:0] BPSK_POS = 16'sh0800;
  localparam logic signed [AWGN_W-1:0] BPSK_NEG = 16'shF800;

  // Clamp x into [-2^(w-1), 2^(w-1)-1]; w must be in 2..31.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/awgn_scale_mult.sv
// Module awgn_scale_mult
//  Registered sigma scaling: scaled = round_half_up(sample * scale / 2^SCALE_FR).
//  sample is signed, scale is unsigned; result is W+2 bits signed, enough for
//  the full range of a Q1.15 multiplier just under 2.0.
// Ports
//  clk, rst      clock, synchronous active-high reset
//  en            advance enable (low = hold output register)
//  in_valid      sample/scale qualify
//  sample        signed W-bit input sample
//  scale         unsigned W-bit multiplier
//  out_valid     registered valid
//  scaled        registered signed W+2-bit result
module awgn_scale_mult #(
  parameter int W        = 16,
  parameter int SCALE_FR = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [W-1:0]        sample,
  input  logic [W-1:0]        scale,
  output logic                out_valid,
  output logic signed [W+1:0] scaled
);

  localparam int PW = 2 * W + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (SCALE_FR - 1);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  logic signed [W+1:0]  scaled_next;

  // Both operands widened to the full product width so the multiply is exact
  // and no implicit context extension is involved.
  always_comb begin
    a_ext       = {{(W + 1){sample[W-1]}}, sample};
    b_ext       = {{(W + 1){1'b0}}, scale};
    prod        = a_ext * b_ext;
    rnd         = prod + HALF;
    scaled_next = (W + 2)'(rnd >>> SCALE_FR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      scaled    <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        scaled <= scaled_next;
      end
    end
  end

endmodule

// File: rtl/awgn_channel.sv
// Module awgn_channel
//  BPSK + scaled AWGN channel model. Each accepted data bit is mapped to
//  +/-AMP, the noise sample captured with it is scaled by noise_scale, the two
//  are added and saturated into a signed Q4.11 soft symbol. 3-stage pipeline
//  (capture, scale, add/saturate) with a single global stall.
// Ports
//  clk, rst       clock, synchronous active-high reset
//  awgn_in        signed Q4.11 noise sample, new value every cycle
//  noise_scale    unsigned Q1.15 sigma multiplier, sampled on accept
//  in_valid/in_ready/in_bit     input handshake; bit 0 -> +AMP, 1 -> -AMP
//  out_valid/out_ready/soft_out output handshake, soft symbol
//  out_last       last symbol of a FRAME_LEN-symbol frame
//  sym_count      output handshakes since reset (wrapping)
// Optional build macro AWGN_CHAN_STATS_EN adds:
//  sat_count      saturating count of saturated symbols handed downstream
//  stats_clr      synchronous clear of sat_count (wins over increment)
module awgn_channel
  import awgn_pkg::*;
#(
  parameter int W         = AWGN_W,
  parameter int AMP       = AMP_DEF,
  parameter int SCALE_FR  = SCALE_FR_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] awgn_in,
  input  logic [W-1:0] noise_scale,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] soft_out,
  output logic         out_last,
  output logic [31:0]  sym_count
`ifdef AWGN_CHAN_STATS_EN
  ,
  output logic [15:0]  sat_count,
  input  logic         stats_clr
`endif
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic signed [W+2:0] AMP_P = (W + 3)'(AMP);
  localparam logic signed [W+2:0] AMP_N = -AMP_P;

  logic stall;
  logic accept;
  logic out_hs;

  // S1: capture
  logic         s1_valid_reg;
  logic         s1_bit_reg;
  logic [W-1:0] s1_awgn_reg;
  logic [W-1:0] s1_scale_reg;

  // S2: scaled noise (inside awgn_scale_mult) plus the data bit riding along
  logic                s2_valid;
  logic signed [W+1:0] s2_n;
  logic                s2_bit_reg;

  // S3: output register
  logic                out_valid_reg;
  logic [W-1:0]        soft_out_reg;
  logic                sat_reg;
  logic signed [W+2:0] sum_next;
  logic signed [31:0]  sum_ext;
  logic [W-1:0]        soft_next;
  logic                sat_next;

  logic [CW-1:0] frame_cnt_reg;
  logic [31:0]   sym_count_reg;

  // Only a held output can stall; an empty output stage always lets data in.
  assign stall    = out_valid_reg & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_bit_reg   <= 1'b0;
      s1_awgn_reg  <= '0;
      s1_scale_reg <= '0;
    end else if (!stall) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_bit_reg   <= in_bit;
        s1_awgn_reg  <= awgn_in;
        s1_scale_reg <= noise_scale;
      end
    end
  end

  awgn_scale_mult #(
    .W        (W),
    .SCALE_FR (SCALE_FR)
  ) u_scale (
    .clk       (clk),
    .rst       (rst),
    .en        (~stall),
    .in_valid  (s1_valid_reg),
    .sample    (s1_awgn_reg),
    .scale     (s1_scale_reg),
    .out_valid (s2_valid),
    .scaled    (s2_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_bit_reg <= 1'b0;
    end else if (!stall && s1_valid_reg) begin
      s2_bit_reg <= s1_bit_reg;
    end
  end

  always_comb begin
    sum_next  = {s2_n[W+1], s2_n} + (s2_bit_reg ? AMP_N : AMP_P);
    sum_ext   = 32'(sum_next);
    soft_next = W'(sat_w(sum_ext, W));
    sat_next  = (sum_ext != sat_w(sum_ext, W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      soft_out_reg  <= '0;
      sat_reg       <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= s2_valid;
      if (s2_valid) begin
        soft_out_reg <= soft_next;
        sat_reg      <= sat_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      sym_count_reg <= '0;
    end else if (out_hs) begin
      frame_cnt_reg <= (frame_cnt_reg == LAST_IDX) ? '0 : CW'(frame_cnt_reg + 1'b1);
      sym_count_reg <= sym_count_reg + 32'd1;
    end
  end

  assign out_valid = out_valid_reg;
  assign soft_out  = soft_out_reg;
  assign out_last  = out_valid_reg & (frame_cnt_reg == LAST_IDX);
  assign sym_count = sym_count_reg;

`ifdef AWGN_CHAN_STATS_EN
  logic [15:0] sat_count_reg;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      sat_count_reg <= '0;
    end else if (out_hs && sat_reg && sat_count_reg != 16'hFFFF) begin
      sat_count_reg <= sat_count_reg + 16'd1;
    end
  end

  assign sat_count = sat_count_reg;
`endif

endmodule
